// File: rtl/tl_resp_router.sv
// TileLink-style D-channel response router: one slave stream fanned out to
// per-master ports by source ID, burst-locked, with a single registered slot.
module tl_resp_router #(
    parameter int NUM_MASTERS = 2,
    parameter int SRC_W       = 2,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 3,
    parameter int OP_W        = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_opcode,
    input  logic [SRC_W-1:0]       in_source,
    input  logic [LEN_W-1:0]       in_len,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_denied,
    output logic [NUM_MASTERS-1:0] out_valid,
    input  logic [NUM_MASTERS-1:0] out_ready,
    output logic [OP_W-1:0]        out_opcode,
    output logic [SRC_W-1:0]       out_source,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_denied,
    output logic                   out_last,
    output logic                   err_unmapped,
    input  logic                   err_clear
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    localparam logic [SRC_W:0] LP_NM = (SRC_W+1)'(NUM_MASTERS);

    logic [1:0]             r_state;
    logic [LEN_W-1:0]       r_cnt;
    logic [SRC_W-1:0]       r_sel;
    logic                   r_full;
    logic [OP_W-1:0]        r_opcode;
    logic [SRC_W-1:0]       r_source;
    logic [DATA_W-1:0]      r_data;
    logic                   r_denied;
    logic                   r_last;
    logic                   r_err;

    logic [NUM_MASTERS-1:0] w_valid;
    logic                   w_drain;
    logic                   w_mapped;
    logic                   w_acc;
    logic                   w_idle;
    logic                   w_load;
    logic                   w_len0;
    logic                   w_cnt_one;
    logic                   w_last_beat;

    always_comb begin
        w_valid = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_valid[k] = r_full && (r_sel == SRC_W'(k));
        end
    end

    assign w_drain     = |(w_valid & out_ready);
    assign w_mapped    = {1'b0, in_source} < LP_NM;
    assign w_idle      = (r_state == S_IDLE);
    assign in_ready    = (r_state == S_DROP) || !r_full || w_drain;
    assign w_acc       = in_valid && in_ready;
    assign w_load      = w_acc && ((w_idle && w_mapped) || r_state == S_BURST);
    assign w_len0      = (in_len == '0);
    assign w_cnt_one   = (r_cnt == LEN_W'(1));
    // Last-beat flag comes from burst position only.
    assign w_last_beat = w_idle ? w_len0 : w_cnt_one;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_full   <= 1'b0;
            r_opcode <= '0;
            r_source <= '0;
            r_data   <= '0;
            r_denied <= 1'b0;
            r_last   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_load) begin
                r_full   <= 1'b1;
                r_opcode <= in_opcode;
                r_source <= w_idle ? in_source : r_sel;
                r_data   <= in_data;
                r_denied <= in_denied;
                r_last   <= w_last_beat;
            end else if (w_drain) begin
                r_full <= 1'b0;
            end

            if (w_acc && w_idle && !w_mapped) begin
                r_err <= 1'b1;
            end else if (err_clear) begin
                r_err <= 1'b0;
            end

            if (w_acc) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_mapped) begin
                            r_sel <= in_source;
                        end
                        if (!w_len0) begin
                            r_cnt   <= in_len;
                            r_state <= w_mapped ? S_BURST : S_DROP;
                        end
                    end
                    S_BURST, S_DROP: begin
                        r_cnt <= r_cnt - 1'b1;
                        if (w_cnt_one) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign out_valid    = w_valid;
    assign out_opcode   = r_opcode;
    assign out_source   = r_source;
    assign out_data     = r_data;
    assign out_denied   = r_denied;
    assign out_last     = r_last;
    assign err_unmapped = r_err;

endmodule

// File: tb/tb_tl_resp_router.sv
// Directed self-checking bench for tl_resp_router.
module tb_tl_resp_router;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_opcode = '0;
    logic [1:0]  in_source = '0;
    logic [2:0]  in_len = '0;
    logic [31:0] in_data = '0;
    logic        in_denied = 1'b0;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready = 2'b11;
    logic [2:0]  out_opcode;
    logic [1:0]  out_source;
    logic [31:0] out_data;
    logic        out_denied;
    logic        out_last;
    logic        err_unmapped;
    logic        err_clear = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    tl_resp_router dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_source(in_source),
        .in_len(in_len), .in_data(in_data), .in_denied(in_denied),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_source(out_source),
        .out_data(out_data), .out_denied(out_denied),
        .out_last(out_last), .err_unmapped(err_unmapped),
        .err_clear(err_clear)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic [1:0] src, input logic [2:0] len,
                         input logic [31:0] data, input logic den);
        in_valid  = 1'b1;
        in_source = src;
        in_len    = len;
        in_data   = data;
        in_denied = den;
        in_opcode = 3'(src) + 3'd1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        chk("rst_err", 64'(err_unmapped), 64'h0);
        chk("rst_last", 64'(out_last), 64'h0);
        chk("rst_data", 64'(out_data), 64'h0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Single beats to each master, back to back.
        drive(2'd0, 3'd0, 32'hA5A5_0001, 1'b0);
        tick();
        chk("s1_valid", 64'(out_valid), 64'h1);
        chk("s1_data", 64'(out_data), 64'hA5A5_0001);
        chk("s1_last", 64'(out_last), 64'h1);
        chk("s1_op", 64'(out_opcode), 64'h1);
        drive(2'd1, 3'd0, 32'h0000_0002, 1'b1);
        #1 chk("s2_ready", 64'(in_ready), 64'h1);
        tick();
        chk("s2_valid", 64'(out_valid), 64'h2);
        chk("s2_data", 64'(out_data), 64'h2);
        chk("s2_last", 64'(out_last), 64'h1);
        chk("s2_src", 64'(out_source), 64'h1);
        chk("s2_den", 64'(out_denied), 64'h1);
        in_valid = 1'b0;
        tick();
        chk("s_idle", 64'(out_valid), 64'h0);

        // Burst lock: head to master 1, later beats carry source 0.
        for (int i = 0; i < 4; i++) begin
            drive((i == 0) ? 2'd1 : 2'd0, (i == 0) ? 3'd3 : 3'd0,
                  32'h10 + 32'(i), 1'b0);
            #1 chk("b_ready", 64'(in_ready), 64'h1);
            tick();
            chk("b_valid", 64'(out_valid), 64'h2);
            chk("b_data", 64'(out_data), 64'h10 + 64'(i));
            chk("b_last", 64'(out_last), (i == 3) ? 64'h1 : 64'h0);
        end
        in_valid = 1'b0;
        tick();

        // Backpressure on master 0 during a 2-beat burst.
        out_ready = 2'b10;
        drive(2'd0, 3'd1, 32'h20, 1'b0);
        tick();
        chk("bp_valid0", 64'(out_valid), 64'h1);
        chk("bp_last0", 64'(out_last), 64'h0);
        drive(2'd0, 3'd0, 32'h21, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1 chk("bp_stall", 64'(in_ready), 64'h0);
            tick();
            chk("bp_hold_v", 64'(out_valid), 64'h1);
            chk("bp_hold_d", 64'(out_data), 64'h20);
        end
        out_ready = 2'b11;
        #1 chk("bp_ready", 64'(in_ready), 64'h1);
        tick();
        chk("bp_valid1", 64'(out_valid), 64'h1);
        chk("bp_data1", 64'(out_data), 64'h21);
        chk("bp_last1", 64'(out_last), 64'h1);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", 64'(out_valid), 64'h0);

        // Unmapped source 3, 3-beat burst is dropped.
        for (int i = 0; i < 3; i++) begin
            drive((i == 0) ? 2'd3 : 2'd0, (i == 0) ? 3'd2 : 3'd0,
                  32'h30 + 32'(i), 1'b0);
            #1 chk("u_ready", 64'(in_ready), 64'h1);
            tick();
            chk("u_valid", 64'(out_valid), 64'h0);
            chk("u_err", 64'(err_unmapped), 64'h1);
        end
        drive(2'd0, 3'd0, 32'h40, 1'b0);
        tick();
        chk("u_next_v", 64'(out_valid), 64'h1);
        chk("u_next_d", 64'(out_data), 64'h40);
        chk("u_next_l", 64'(out_last), 64'h1);
        in_valid  = 1'b0;
        err_clear = 1'b1;
        tick();
        chk("u_clear", 64'(err_unmapped), 64'h0);

        // Set wins over clear.
        drive(2'd2, 3'd0, 32'h50, 1'b0);
        tick();
        chk("sc_err", 64'(err_unmapped), 64'h1);
        chk("sc_valid", 64'(out_valid), 64'h0);
        in_valid  = 1'b0;
        err_clear = 1'b0;
        tick();

        // Reset in the middle of a 4-beat burst to master 1.
        drive(2'd1, 3'd3, 32'h60, 1'b0);
        tick();
        drive(2'd1, 3'd0, 32'h61, 1'b0);
        tick();
        chk("r_pre_v", 64'(out_valid), 64'h2);
        chk("r_pre_d", 64'(out_data), 64'h61);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("r_async_v", 64'(out_valid), 64'h0);
        chk("r_async_d", 64'(out_data), 64'h0);
        chk("r_async_r", 64'(in_ready), 64'h1);
        chk("r_async_l", 64'(out_last), 64'h0);
        @(negedge clock);
        reset = 1'b1;
        drive(2'd0, 3'd0, 32'h70, 1'b0);
        tick();
        chk("r_post_v", 64'(out_valid), 64'h1);
        chk("r_post_l", 64'(out_last), 64'h1);
        chk("r_post_d", 64'(out_data), 64'h70);
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
